// File: rtl/ddr3_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_dma_pkg
//  Description : Shared constants and state encoding for the DDR3 DMA
//                ping-pong FIFO adapters (write and read side).
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr3_dma_pkg;

    // Number of banks in the ping-pong FIFO
    localparam int PPFIFO_BANKS = 2;

    // Stream / FIFO data word width
    localparam int DATA_WIDTH = 32;

    // Adapter state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] ppw_state_t;

    localparam ppw_state_t ST_IDLE     = 2'd0;
    localparam ppw_state_t ST_ACTIVATE = 2'd1;
    localparam ppw_state_t ST_FILL     = 2'd2;
    localparam ppw_state_t ST_RELEASE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ppfifo_bank_select.sv
`default_nettype none
// ============================================================================
//  Module      : ppfifo_bank_select
//  Description : Combinational priority pick of a free ping-pong FIFO bank.
//                Turns the per-bank ready vector into a one-hot activate,
//                lowest-numbered bank wins. Shared by read and write adapters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppfifo_bank_select
    import ddr3_dma_pkg::*;
(
    input  logic [PPFIFO_BANKS-1:0] ready_i,
    output logic [PPFIFO_BANKS-1:0] activate_o
);

    localparam logic [PPFIFO_BANKS-1:0] ONE = {{(PPFIFO_BANKS-1){1'b0}}, 1'b1};

    // Isolate the lowest set bit: x & -x; all-zero input gives all-zero output
    assign activate_o = ready_i & (~ready_i + ONE);

endmodule
`default_nettype wire

// File: rtl/ddr3_ppfifo_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_ppfifo_writer
//  Description : Valid/ready word stream to ping-pong FIFO write adapter.
//                Grabs a free bank, fills it up to the advertised size or a
//                stream last, then releases it for the DDR3 DMA.
//  Options     : PPW_TIMEOUT_EN - release a partially filled bank after
//                TIMEOUT_CYCLES idle cycles in FILL.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_ppfifo_writer
    import ddr3_dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int COUNT_WIDTH    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_last,
    output logic                    o_ready,
    input  logic [PPFIFO_BANKS-1:0] write_ready,
    output logic [PPFIFO_BANKS-1:0] write_activate,
    input  logic [COUNT_WIDTH-1:0]  write_size,
    output logic                    write_strobe,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    busy,
    output logic [31:0]             words_total
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    ppw_state_t                state_q, state_d;
    logic [PPFIFO_BANKS-1:0]   activate_q, activate_d;
    logic [PPFIFO_BANKS-1:0]   pick;
    logic [COUNT_WIDTH-1:0]    size_q, size_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      last_seen_q, last_seen_d;
    logic                      holdoff_q, holdoff_d;
    logic                      strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [31:0]               total_q, total_d;
    logic                      accept;

`ifdef PPW_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`else
    // Parameter only matters for the timeout build; kept for a stable interface
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    ppfifo_bank_select u_bank_select (
        .ready_i    (write_ready),
        .activate_o (pick)
    );

    // Next-state logic: handshake, bank ownership, counters and FSM
    always_comb begin
        o_ready     = (state_q == ST_FILL) && (count_q < size_q) && !last_seen_q;
        accept      = i_valid && o_ready;

        state_d     = state_q;
        activate_d  = activate_q;
        size_d      = size_q;
        count_d     = count_q;
        last_seen_d = last_seen_q;
        holdoff_d   = holdoff_q;
        strobe_d    = accept;
        data_d      = accept ? i_data : data_q;
        total_d     = accept ? (total_q + 32'd1) : total_q;
`ifdef PPW_TIMEOUT_EN
        idle_d      = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                // The FIFO ready flag lags one cycle behind a release, so the
                // first IDLE cycle after RELEASE must not look at it.
                holdoff_d = 1'b0;
                if (!holdoff_q && (write_ready != '0)) begin
                    activate_d = pick;
                    state_d    = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                size_d  = write_size;
                count_d = '0;
                state_d = (write_size == '0) ? ST_RELEASE : ST_FILL;
            end
            ST_FILL: begin
                if (accept) begin
                    count_d = count_q + CNT_ONE;
                    if (i_last) begin
                        last_seen_d = 1'b1;
                    end
                    if (((count_q + CNT_ONE) == size_q) || i_last) begin
                        state_d = ST_RELEASE;
                    end
                end
`ifdef PPW_TIMEOUT_EN
                else if (count_q != '0) begin
                    // Flush a partial bank once the stream has gone quiet
                    if (idle_q == IDLE_LIMIT) begin
                        state_d = ST_RELEASE;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            ST_RELEASE: begin
                activate_d  = '0;
                last_seen_d = 1'b0;
                holdoff_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            activate_q  <= '0;
            size_q      <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            holdoff_q   <= 1'b0;
            strobe_q    <= 1'b0;
            data_q      <= '0;
            total_q     <= '0;
`ifdef PPW_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            activate_q  <= activate_d;
            size_q      <= size_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            holdoff_q   <= holdoff_d;
            strobe_q    <= strobe_d;
            data_q      <= data_d;
            total_q     <= total_d;
`ifdef PPW_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    assign write_activate = activate_q;
    assign write_strobe   = strobe_q;
    assign write_data     = data_q;
    assign busy           = (state_q != ST_IDLE);
    assign words_total    = total_q;

endmodule
`default_nettype wire
